// File: rtl/song_recorder.sv
// song_recorder: turns live key press/release events into song RAM words.
// Define SONG_RECORDER_STEAL_EN to steal the longest-held voice on overflow.
module song_recorder #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              record,
    input  logic [1:0]        song,
    input  logic              beat,
    input  logic              key_valid,
    input  logic              key_press,
    input  logic [5:0]        key_note,
    output logic              key_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [2:0]        voice_busy,
    output logic              full,
    output logic              rec_done
);
    localparam int OFF_W = ADDR_W - 2;
    localparam logic [OFF_W-1:0] LAST = '1;
    localparam logic [OFF_W-1:0] LAST_M1 = {{(OFF_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
`ifdef SONG_RECORDER_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, ARMED, WR_ADV, WR_NOTE, WR_REL, FLUSH, WR_END
    } state_t;

    function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic inc);
        return (inc && v != 6'd63) ? v + 6'd1 : v;
    endfunction

    function automatic logic [15:0] note_word(input logic [1:0] v,
                                              input logic [5:0] n,
                                              input logic [5:0] d);
        return {2'b00, v, n, d};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        gap_q, gap_d;
    logic              full_q, full_d;
    logic              stop_q, stop_d;
    logic              rec_prev_q, rec_prev_d;
    logic [2:0]        busy_q, busy_d;
    logic [5:0]        note_q [3];
    logic [5:0]        note_d [3];
    logic [5:0]        cnt_q [3];
    logic [5:0]        cnt_d [3];
    logic [ADDR_W-1:0] slot_q [3];
    logic [ADDR_W-1:0] slot_d [3];
    logic [1:0]        pend_voice_q, pend_voice_d;
    logic [5:0]        pend_note_q, pend_note_d;
    logic [5:0]        pend_adv_q, pend_adv_d;
    logic              pend_go_q, pend_go_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              rec_done_q, rec_done_d;

    logic [5:0]        adv, old_cnt, fin_dur;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              room, hit, go_first, go_fin, go_flush;
    logic [1:0]        free_v, hit_v, low_v, old_v, fin_v, pv;

    assign adv   = sat_inc(gap_q, beat);
    assign off_q = addr_q[OFF_W-1:0];
    // Last word of a region is kept for the end marker.
    assign room  = (off_q != LAST) && !(off_q == LAST_M1 && adv != 6'd0);

    always_comb begin
        free_v  = 2'd0;
        hit     = 1'b0;
        hit_v   = 2'd0;
        low_v   = 2'd0;
        old_v   = 2'd0;
        old_cnt = cnt_q[0];
        for (int i = 2; i >= 0; i--) begin
            if (!busy_q[i]) free_v = 2'(i);
            if (busy_q[i]) low_v = 2'(i);
            if (busy_q[i] && note_q[i] == key_note) begin
                hit   = 1'b1;
                hit_v = 2'(i);
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (cnt_q[i] > old_cnt) begin
                old_cnt = cnt_q[i];
                old_v   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        gap_d        = gap_q;
        full_d       = full_q;
        stop_d       = stop_q;
        rec_prev_d   = record;
        busy_d       = busy_q;
        note_d       = note_q;
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        pend_voice_d = pend_voice_q;
        pend_note_d  = pend_note_q;
        pend_adv_d   = pend_adv_q;
        pend_go_d    = pend_go_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rec_done_d   = 1'b0;
        go_first     = 1'b0;
        go_fin       = 1'b0;
        go_flush     = 1'b0;
        fin_v        = 2'd0;
        pv           = 2'd0;
        fin_dur      = 6'd0;
        off_d        = '0;

        if (state_q != IDLE) begin
            gap_d  = adv;
            stop_d = stop_q | ~record;
            for (int i = 0; i < 3; i++) begin
                if (busy_q[i]) cnt_d[i] = sat_inc(cnt_q[i], beat);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (record && !rec_prev_q) begin
                    state_d   = ARMED;
                    addr_d    = {song, {OFF_W{1'b0}}};
                    gap_d     = 6'd0;
                    busy_d    = 3'b000;
                    full_d    = 1'b0;
                    stop_d    = 1'b0;
                    pend_go_d = 1'b0;
                end
            end
            ARMED: begin
                if (key_valid) begin
                    if (key_press) begin
                        if (key_note != 6'd0 && !hit && !full_q && room &&
                            (busy_q != 3'b111 || STEAL_EN)) begin
                            go_fin       = (busy_q == 3'b111);
                            go_first     = !go_fin;
                            fin_v        = old_v;
                            pv           = go_fin ? old_v : free_v;
                            pend_go_d    = go_fin;
                            pend_voice_d = pv;
                            pend_note_d  = key_note;
                            pend_adv_d   = adv;
                            busy_d[pv]   = 1'b1;
                            note_d[pv]   = key_note;
                            cnt_d[pv]    = 6'd0;
                            slot_d[pv]   = addr_q + ADDR_W'(adv != 6'd0);
                            gap_d        = 6'd0;
                            if (go_fin) state_d = WR_REL;
                        end
                    end else if (key_note != 6'd0 && hit) begin
                        go_fin        = 1'b1;
                        fin_v         = hit_v;
                        busy_d[hit_v] = 1'b0;
                        state_d       = WR_REL;
                    end
                end else if (stop_q || !record) begin
                    go_flush = 1'b1;
                end
            end
            WR_ADV: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = note_word(pend_voice_q, pend_note_q, 6'd0);
                addr_d    = addr_q + ONE;
                state_d   = WR_NOTE;
            end
            WR_NOTE: state_d = ARMED;
            WR_REL: begin
                if (pend_go_q) begin
                    go_first  = 1'b1;
                    pend_go_d = 1'b0;
                end else begin
                    state_d = ARMED;
                end
            end
            FLUSH: go_flush = 1'b1;
            WR_END: begin
                rec_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (go_flush) begin
            wr_en_d = 1'b1;
            if (|busy_q) begin
                go_fin        = 1'b1;
                fin_v         = low_v;
                busy_d[low_v] = 1'b0;
                state_d       = FLUSH;
            end else begin
                wr_addr_d = addr_q;
                wr_data_d = 16'h0000;
                state_d   = WR_END;
            end
        end

        if (go_fin) begin
            fin_dur   = (cnt_q[fin_v] == 6'd0) ? 6'd1 : cnt_q[fin_v];
            wr_en_d   = 1'b1;
            wr_addr_d = slot_q[fin_v];
            wr_data_d = note_word(fin_v, note_q[fin_v], fin_dur);
        end

        if (go_first) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            addr_d    = addr_q + ONE;
            if (pend_adv_d != 6'd0) begin
                wr_data_d = {1'b1, 9'd0, pend_adv_d};
                state_d   = WR_ADV;
            end else begin
                wr_data_d = note_word(pend_voice_d, pend_note_d, 6'd0);
                state_d   = WR_NOTE;
            end
        end

        off_d = addr_d[OFF_W-1:0];
        if (state_q != IDLE &&
            (off_d == LAST || (off_d == LAST_M1 && gap_d != 6'd0)))
            full_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            gap_q        <= '0;
            full_q       <= 1'b0;
            stop_q       <= 1'b0;
            rec_prev_q   <= 1'b0;
            busy_q       <= '0;
            note_q       <= '{default: '0};
            cnt_q        <= '{default: '0};
            slot_q       <= '{default: '0};
            pend_voice_q <= '0;
            pend_note_q  <= '0;
            pend_adv_q   <= '0;
            pend_go_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rec_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            gap_q        <= gap_d;
            full_q       <= full_d;
            stop_q       <= stop_d;
            rec_prev_q   <= rec_prev_d;
            busy_q       <= busy_d;
            note_q       <= note_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            pend_voice_q <= pend_voice_d;
            pend_note_q  <= pend_note_d;
            pend_adv_q   <= pend_adv_d;
            pend_go_q    <= pend_go_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rec_done_q   <= rec_done_d;
        end
    end

    assign key_ready  = (state_q == ARMED);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign voice_busy = busy_q;
    assign full       = full_q;
    assign rec_done   = rec_done_q;

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: cycle table for a single-note take plus directed
// sequences for chords, gaps, voice overflow, region fill and reset.
module tb_song_recorder;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset, record, beat, key_valid, key_press;
    logic [1:0]    song;
    logic [5:0]    key_note;
    logic          key_ready, wr_en, full, rec_done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [2:0]    voice_busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [AW+15:0] wq[$];
    logic [AW+15:0] eq[$];

    song_recorder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .record(record), .song(song),
        .beat(beat), .key_valid(key_valid), .key_press(key_press),
        .key_note(key_note), .key_ready(key_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .voice_busy(voice_busy),
        .full(full), .rec_done(rec_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
        if (rec_done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic          rec;
        logic          bt;
        logic          kv;
        logic          kp;
        logic [5:0]    kn;
        logic          kr;
        logic          we;
        logic [AW-1:0] wa;
        logic [15:0]   wd;
        logic [2:0]    vb;
        logic          rd;
    } vec_t;

    function automatic vec_t mk(input logic rec, input logic bt,
                                input logic kv, input logic kp,
                                input logic [5:0] kn, input logic kr,
                                input logic we, input logic [AW-1:0] wa,
                                input logic [15:0] wd, input logic [2:0] vb,
                                input logic rd);
        vec_t v;
        v.rec = rec; v.bt = bt; v.kv = kv; v.kp = kp; v.kn = kn;
        v.kr = kr; v.we = we; v.wa = wa; v.wd = wd; v.vb = vb; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic ew(input int a, input int d);
        eq.push_back({AW'(a), 16'(d)});
    endtask

    task automatic cmp_writes(input string name);
        chk({name, " count"}, wq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < wq.size(); i++)
            chk($sformatf("%s w%0d", name, i), 32'(wq[i]), 32'(eq[i]));
        wq.delete();
        eq.delete();
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (key_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("key_ready wait", key_ready, 1);
    endtask

    task automatic key(input logic p, input logic [5:0] n);
        wait_ready();
        key_valid = 1'b1;
        key_press = p;
        key_note  = n;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic beats(input int n);
        wait_ready();
        for (int i = 0; i < n; i++) begin
            beat = 1'b1;
            @(negedge clk);
            beat = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic start_take(input logic [1:0] s);
        song   = s;
        record = 1'b1;
        @(negedge clk);
        chk("armed", key_ready, 1);
    endtask

    task automatic stop_take();
        int t;
        int d0;
        t  = 0;
        d0 = done_cnt;
        wait_ready();
        record = 1'b0;
        while (done_cnt == d0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("rec_done pulses", done_cnt - d0, 1);
    endtask

    initial begin
        vec_t tv[11];
        reset = 1'b0; record = 1'b0; song = 2'd0; beat = 1'b0;
        key_valid = 1'b0; key_press = 1'b0; key_note = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst key_ready", key_ready, 0);
        chk("rst voice_busy", voice_busy, 0);
        chk("rst full", full, 0);
        chk("rst rec_done", rec_done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Song 1: press 20, three beats, release, stop.
        tv[0]  = mk(1, 0, 0, 0, 0,  1, 0, 0,  16'h0000, 3'b000, 0);
        tv[1]  = mk(1, 0, 1, 1, 20, 0, 1, 32, 16'h0500, 3'b001, 0);
        tv[2]  = mk(1, 0, 0, 0, 0,  1, 0, 0,  16'h0000, 3'b001, 0);
        tv[3]  = mk(1, 1, 0, 0, 0,  1, 0, 0,  16'h0000, 3'b001, 0);
        tv[4]  = mk(1, 1, 0, 0, 0,  1, 0, 0,  16'h0000, 3'b001, 0);
        tv[5]  = mk(1, 1, 0, 0, 0,  1, 0, 0,  16'h0000, 3'b001, 0);
        tv[6]  = mk(1, 0, 1, 0, 20, 0, 1, 32, 16'h0503, 3'b000, 0);
        tv[7]  = mk(1, 0, 0, 0, 0,  1, 0, 0,  16'h0000, 3'b000, 0);
        tv[8]  = mk(0, 0, 0, 0, 0,  0, 1, 33, 16'h0000, 3'b000, 0);
        tv[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  16'h0000, 3'b000, 1);
        tv[10] = mk(0, 0, 0, 0, 0,  0, 0, 0,  16'h0000, 3'b000, 0);
        song = 2'd1;
        for (int i = 0; i < 11; i++) begin
            record    = tv[i].rec;
            beat      = tv[i].bt;
            key_valid = tv[i].kv;
            key_press = tv[i].kp;
            key_note  = tv[i].kn;
            @(negedge clk);
            chk($sformatf("v%0d key_ready", i), key_ready, tv[i].kr);
            chk($sformatf("v%0d wr_en", i), wr_en, tv[i].we);
            chk($sformatf("v%0d voice_busy", i), voice_busy, tv[i].vb);
            chk($sformatf("v%0d full", i), full, 0);
            chk($sformatf("v%0d rec_done", i), rec_done, tv[i].rd);
            if (tv[i].we) begin
                chk($sformatf("v%0d wr_addr", i), wr_addr, tv[i].wa);
                chk($sformatf("v%0d wr_data", i), wr_data, tv[i].wd);
            end
        end
        beat = 1'b0; key_valid = 1'b0;
        wq.delete();

        // Chord in song 0.
        start_take(2'd0);
        key(1, 10);
        key(1, 14);
        key(1, 17);
        wait_ready();
        chk("chord busy", voice_busy, 3'b111);
        beats(4);
        key(0, 10);
        key(0, 14);
        key(0, 17);
        stop_take();
        ew(0, 16'h0280); ew(1, 16'h1380); ew(2, 16'h2440);
        ew(0, 16'h0284); ew(1, 16'h1384); ew(2, 16'h2444);
        ew(3, 16'h0000);
        cmp_writes("chord");

        // Gap of nine beats in song 2.
        start_take(2'd2);
        key(1, 5);
        beats(2);
        key(0, 5);
        beats(7);
        key(1, 6);
        stop_take();
        ew(64, 16'h0140); ew(64, 16'h0142);
        ew(65, 16'h8009); ew(66, 16'h0180);
        ew(66, 16'h0181); ew(67, 16'h0000);
        cmp_writes("gap");

        // Fourth press with three voices held, song 3.
        start_take(2'd3);
        key(1, 1);
        key(1, 2);
        key(1, 3);
        beats(2);
        key(1, 4);
        wait_ready();
        chk("overflow busy", voice_busy, 3'b111);
        key(0, 1);
        key(0, 2);
        key(0, 3);
        stop_take();
`ifdef SONG_RECORDER_STEAL_EN
        ew(96, 16'h0040); ew(97, 16'h1080); ew(98, 16'h20C0);
        ew(96, 16'h0042); ew(99, 16'h8002); ew(100, 16'h0100);
        ew(97, 16'h1082); ew(98, 16'h20C2);
        ew(100, 16'h0101); ew(101, 16'h0000);
`else
        ew(96, 16'h0040); ew(97, 16'h1080); ew(98, 16'h20C0);
        ew(96, 16'h0042); ew(97, 16'h1082); ew(98, 16'h20C2);
        ew(99, 16'h0000);
`endif
        cmp_writes("overflow");

        // Fill song 0 up to its reserved last word.
        start_take(2'd0);
        for (int i = 0; i < 30; i++) begin
            key(1, 6'(i + 1));
            key(0, 6'(i + 1));
            ew(i, (i + 1) << 6);
            ew(i, ((i + 1) << 6) | 1);
        end
        wait_ready();
        chk("fill not yet full", full, 0);
        key(1, 40);
        wait_ready();
        chk("fill full", full, 1);
        key(1, 41);
        wait_ready();
        chk("fill drop busy", voice_busy, 3'b001);
        key(0, 40);
        stop_take();
        chk("full held after take", full, 1);
        ew(30, 16'h0A00); ew(30, 16'h0A01); ew(31, 16'h0000);
        cmp_writes("fill");

        // Reset while the advance word is on the bus.
        start_take(2'd1);
        chk("new take clears full", full, 0);
        beats(1);
        wait_ready();
        key_valid = 1'b1; key_press = 1'b1; key_note = 6'd7;
        @(negedge clk);
        key_valid = 1'b0;
        chk("adv wr_en", wr_en, 1);
        chk("adv wr_addr", wr_addr, 32);
        chk("adv wr_data", wr_data, 16'h8001);
        reset = 1'b0;
        @(negedge clk);
        chk("mid rst wr_en", wr_en, 0);
        chk("mid rst wr_addr", wr_addr, 0);
        chk("mid rst wr_data", wr_data, 0);
        chk("mid rst key_ready", key_ready, 0);
        chk("mid rst voice_busy", voice_busy, 0);
        chk("mid rst full", full, 0);
        chk("mid rst rec_done", rec_done, 0);
        record = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        chk("post rst idle", key_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
